// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store access.
// Define MEM_ARB_RR_EN for round-robin arbitration; by default data requests have fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_stall,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a requester holds *_req high with stable operands until its one-cycle
    // *_valid (shown in RESP); the arbiter holds mem_req and mem_* stable until mem_ready.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic              grant_data_d;
    logic              grant_if_d;

`ifdef MEM_ARB_RR_EN
    // last_grant_q: 0 = fetch won the last contest, 1 = data won it.
    // Only contested grants move it, so a lone requester never shifts priority.
    logic last_grant_q;

    assign grant_data_d = d_req & (~if_req | ~last_grant_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b0;
        end else if (state_q == IDLE && d_req && if_req) begin
            last_grant_q <= grant_data_d;
        end
    end
`else
    assign grant_data_d = d_req;
`endif

    assign grant_if_d = if_req & ~grant_data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_we ? d_wdata : '0;
                        mem_be_q    <= d_we ? d_be : '1;
                        state_q     <= BUSY_D;
                    end else if (grant_if_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                        state_q     <= BUSY_IF;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_rdata_q <= mem_rdata;
                        if_valid_q <= 1'b1;
                        state_q    <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        // Stores complete without disturbing the last load result.
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        d_valid_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_valid    = if_valid_q;
    assign d_valid     = d_valid_q;
    assign pc_stall    = if_req & ~if_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by randomized fetch/data traffic.
// Honours MEM_ARB_RR_EN the same way as the design when choosing the expected grant order.
module tb_mem_port_arbiter;
  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        pc_stall;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc_stall(pc_stall), .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fixed_wait = 0;      // -1: random wait states
  int spurious_mode = 0;   // 0 none, 1 random, 2 always high outside a transaction

  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] env_mem[int unsigned];
  logic [31:0] last_load = 0;

  // Requests not yet granted, with the time they were raised
  bit          f_pend = 0;
  time         f_t;
  logic [31:0] fp_addr;
  bit          d_pend = 0;
  time         d_t;
  logic        dp_we;
  logic [31:0] dp_addr;
  logic [31:0] dp_wdata;
  logic [3:0]  dp_be;
`ifdef MEM_ARB_RR_EN
  bit          last_contest_d = 0;
`endif

  // ---------------- clock / reset ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_val(a);
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a[31:2]) ? env_mem[a[31:2]] : init_val(a);
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic do_fetch(input logic [31:0] addr, input bit hold, output int lat);
    int start;
    bit got;
    got = 0;
    start = cyc;
    if_addr = addr;
    if_req = 1;
    if_exp_q.push_back(ref_read(addr));
    fp_addr = addr;
    f_t = $time;
    f_pend = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fetch_timeout addr=%h no if_valid within 200 cycles", addr);
    end
    lat = cyc - start;
    if (!hold) if_req = 0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat);
    int start;
    bit got;
    got = 0;
    start = cyc;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    d_be = be;
    d_req = 1;
    if (we) ref_mem[addr[31:2]] = merge(ref_read(addr), wdata, be);
    else last_load = ref_read(addr);
    d_exp_q.push_back(last_load);
    dp_we = we;
    dp_addr = addr;
    dp_wdata = wdata;
    dp_be = be;
    d_t = $time;
    d_pend = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_valid) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL data_timeout addr=%h no d_valid within 200 cycles", addr);
    end
    lat = cyc - start;
    d_req = 0;
  endtask

  // ---------------- memory responder + grant checker ----------------
  initial begin
    bit          in_txn;
    int          wait_left;
    bit          fa, da, pick_d;
    time         gt;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;
    in_txn = 0;
    wait_left = 0;
    mem_ready = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mem_req) begin
        in_txn = 0;
        mem_ready = (spurious_mode == 2) || (spurious_mode == 1 && $urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          gt = $time - 5;
          fa = f_pend && (f_t < gt);
          da = d_pend && (d_t < gt);
          if (!fa && !da) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected mem_addr=%h with no pending request", mem_addr);
          end else begin
            if (fa && da) begin
`ifdef MEM_ARB_RR_EN
              pick_d = !last_contest_d;
              last_contest_d = pick_d;
`else
              pick_d = 1;
`endif
            end else begin
              pick_d = da;
            end
            if (pick_d) begin
              chk("grant_d_we", mem_we, dp_we);
              chk("grant_d_addr", mem_addr, dp_addr);
              chk("grant_d_be", mem_be, dp_we ? dp_be : 4'hF);
              if (dp_we) chk("grant_d_wdata", mem_wdata, dp_wdata);
              d_pend = 0;
            end else begin
              chk("grant_if_we", mem_we, 0);
              chk("grant_if_addr", mem_addr, fp_addr);
              chk("grant_if_be", mem_be, 4'hF);
              f_pend = 0;
            end
          end
          cap_we = mem_we;
          cap_be = mem_be;
          cap_addr = mem_addr;
          cap_wdata = mem_wdata;
          wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
        end else begin
          chk("stable_addr", mem_addr, cap_addr);
          chk("stable_wdata", mem_wdata, cap_wdata);
          chk("stable_ctl", {27'b0, mem_we, mem_be}, {27'b0, cap_we, cap_be});
        end
        if (wait_left == 0) begin
          mem_ready = 1;
          if (mem_we) begin
            env_mem[mem_addr[31:2]] = merge(env_read(mem_addr), mem_wdata, mem_be);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = env_read(mem_addr);
          end
          in_txn = 0;
        end else begin
          wait_left--;
          mem_ready = 0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (if_valid) begin
      if (if_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL if_valid_unexpected if_rdata=%h with nothing outstanding", if_rdata);
      end else begin
        chk("if_rdata", if_rdata, if_exp_q.pop_front());
      end
    end
    if (d_valid) begin
      if (d_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d_valid_unexpected d_rdata=%h with nothing outstanding", d_rdata);
      end else begin
        chk("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
    chk("pc_stall", pc_stall, if_req & ~if_valid);
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_valids"}, {if_valid, d_valid}, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, lat2;
    reset_n = 0;
    if_req = 0;
    if_addr = 0;
    d_req = 0;
    d_we = 0;
    d_addr = 0;
    d_wdata = 0;
    d_be = 0;
    ref_mem[32'h100 >> 2] = 32'h0050_0093;
    env_mem[32'h100 >> 2] = 32'h0050_0093;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1;

    // Spurious ready with no requests
    spurious_mode = 2;
    repeat (5) @(negedge clk);
    chk_idle_outputs("spurious");
    spurious_mode = 0;
    repeat (2) @(negedge clk);

    // Fetch only, zero wait states
    fixed_wait = 0;
    do_fetch(32'h100, 0, lat);
    chk("lat_fetch", lat, 2);
    repeat (2) @(negedge clk);

    // Back-to-back fetches with if_req held across RESP
    do_fetch(32'h100, 1, lat);
    do_fetch(32'h104, 0, lat2);
    chk("lat_fetch_b2b", lat + lat2, 5);
    repeat (2) @(negedge clk);

    // Two simultaneous pairs: first favours data; the second depends on the arbitration mode
    fork
      do_fetch(32'h200, 0, lat);
      do_data(1'b0, 32'h2000, 32'h0, 4'h0, lat2);
    join
    chk("lat_pair_data", lat2, 2);
    chk("lat_pair_fetch", lat, 5);
    repeat (2) @(negedge clk);
    fork
      do_fetch(32'h204, 0, lat);
      do_data(1'b0, 32'h2004, 32'h0, 4'h0, lat2);
    join
`ifdef MEM_ARB_RR_EN
    chk("lat_pair2_fetch", lat, 2);
`else
    chk("lat_pair2_data", lat2, 2);
`endif
    repeat (2) @(negedge clk);

    // Store with three wait states, then read back
    fixed_wait = 3;
    do_data(1'b1, 32'h3004, 32'hDEAD_BEEF, 4'b0011, lat);
    chk("lat_store_wait", lat, 5);
    fixed_wait = 0;
    repeat (2) @(negedge clk);
    do_data(1'b0, 32'h3004, 32'h0, 4'h0, lat);
    repeat (2) @(negedge clk);

    // Reset in the middle of a fetch
    fixed_wait = 5;
    if_addr = 32'h300;
    if_req = 1;
    fp_addr = 32'h300;
    f_t = $time;
    f_pend = 1;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    chk("rst_async_state", dbg_state, 0);
    f_pend = 0;
    last_load = 0;
`ifdef MEM_ARB_RR_EN
    last_contest_d = 0;
`endif
    repeat (2) @(negedge clk);
    fixed_wait = 1;
    reset_n = 1;
    do_fetch(32'h300, 0, lat);
    chk("lat_after_reset", lat, 3);
    repeat (2) @(negedge clk);

    // Randomized concurrent traffic
    fixed_wait = -1;
    spurious_mode = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int l;
          do_fetch({20'b0, 10'($urandom_range(0, 1023)), 2'b00}, ($urandom_range(0, 3) == 0), l);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        if_req = 0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          int l;
          do_data(1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 15)) * 4,
                  $urandom, 4'($urandom_range(1, 15)), l);
          repeat ($urandom_range(2, 5)) @(negedge clk);
        end
      end
    join
    spurious_mode = 0;
    repeat (10) @(negedge clk);
    chk("if_queue_drained", if_exp_q.size(), 0);
    chk("d_queue_drained", d_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
